// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: data-memory request/response handshake,
// store byte-lane formatting, load extension and a registered write-back record.
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_result,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_write,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_rd,
    output logic        o_reg_write,
    output logic        o_excp
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_d;

    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  lo_q, lo_d;
    logic        is_load_q, is_load_d;
    logic [31:0] result_q, result_d;

    logic        dmem_req_d, dmem_we_d;
    logic [31:0] dmem_addr_d, dmem_wdata_d;
    logic [3:0]  dmem_mask_d;
    logic        valid_d, reg_write_out_d, excp_d;
    logic [31:0] wb_data_d;
    logic [4:0]  rd_out_d;

    logic        is_mem, width_bad, misaligned, acc_excp;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign o_stall = (state != IDLE);

    // Decode of the instruction presented upstream: fault detection and store lane layout.
    always_comb begin
        is_mem     = i_mem_read | i_mem_write;
        width_bad  = i_mem_write ? (i_func3 > 3'd2)
                                 : ((i_func3 == 3'b011) || (i_func3[2:1] == 2'b11));
        misaligned = 1'b0;
        case (i_func3[1:0])
            2'b01:   misaligned = i_result[0];
            2'b10:   misaligned = |i_result[1:0];
            default: misaligned = 1'b0;
        endcase
        acc_excp = width_bad | misaligned;

        st_mask  = 4'b1111;
        st_wdata = 32'd0;
        if (i_mem_write) begin
            case (i_func3[1:0])
                2'b00: begin
                    st_mask  = 4'b0001 << i_result[1:0];
                    st_wdata = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    st_mask  = 4'b0011 << i_result[1:0];
                    st_wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    st_mask  = 4'b1111;
                    st_wdata = i_store_data;
                end
            endcase
        end
    end

    // Lane selection and extension of returned load data, using the captured address bits.
    always_comb begin
        ld_byte  = i_dmem_rdata[{lo_q, 3'b000} +: 8];
        ld_half  = lo_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        ld_value = i_dmem_rdata;
        case (func3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'd0, ld_half};
            default: ld_value = i_dmem_rdata;
        endcase
    end

    // Next-state and next-output logic; request fields hold until the handshake completes.
    always_comb begin
        state_d         = state;
        rd_d            = rd_q;
        reg_write_d     = reg_write_q;
        func3_d         = func3_q;
        lo_d            = lo_q;
        is_load_d       = is_load_q;
        result_d        = result_q;
        dmem_req_d      = o_dmem_req;
        dmem_we_d       = o_dmem_we;
        dmem_addr_d     = o_dmem_addr;
        dmem_wdata_d    = o_dmem_wdata;
        dmem_mask_d     = o_dmem_mask;
        valid_d         = 1'b0;
        wb_data_d       = o_wb_data;
        rd_out_d        = o_rd;
        reg_write_out_d = o_reg_write;
        excp_d          = o_excp;

        case (state)
            IDLE: begin
                if (i_valid) begin
                    rd_d        = i_rd;
                    reg_write_d = i_reg_write;
                    func3_d     = i_func3;
                    lo_d        = i_result[1:0];
                    is_load_d   = ~i_mem_write;
                    result_d    = i_result;
                    if (!is_mem || acc_excp) begin
                        valid_d         = 1'b1;
                        wb_data_d       = i_result;
                        rd_out_d        = i_rd;
                        reg_write_out_d = is_mem ? 1'b0 : i_reg_write;
                        excp_d          = is_mem;
                    end else begin
                        state_d      = REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = i_mem_write;
                        dmem_addr_d  = {i_result[31:2], 2'b00};
                        dmem_wdata_d = st_wdata;
                        dmem_mask_d  = st_mask;
                    end
                end
            end
            REQ: begin
                if (i_dmem_ready) begin
                    dmem_req_d = 1'b0;
                    if (is_load_q) begin
                        state_d = RESP;
                    end else begin
                        state_d         = IDLE;
                        valid_d         = 1'b1;
                        wb_data_d       = result_q;
                        rd_out_d        = rd_q;
                        reg_write_out_d = 1'b0;
                        excp_d          = 1'b0;
                    end
                end
            end
            RESP: begin
                if (i_dmem_rvalid) begin
                    state_d         = IDLE;
                    valid_d         = 1'b1;
                    wb_data_d       = ld_value;
                    rd_out_d        = rd_q;
                    reg_write_out_d = reg_write_q;
                    excp_d          = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset abandons any outstanding request and clears the whole record.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            func3_q      <= 3'd0;
            lo_q         <= 2'd0;
            is_load_q    <= 1'b0;
            result_q     <= 32'd0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_mask  <= 4'd0;
            o_valid      <= 1'b0;
            o_wb_data    <= 32'd0;
            o_rd         <= 5'd0;
            o_reg_write  <= 1'b0;
            o_excp       <= 1'b0;
        end else begin
            state        <= state_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            func3_q      <= func3_d;
            lo_q         <= lo_d;
            is_load_q    <= is_load_d;
            result_q     <= result_d;
            o_dmem_req   <= dmem_req_d;
            o_dmem_we    <= dmem_we_d;
            o_dmem_addr  <= dmem_addr_d;
            o_dmem_wdata <= dmem_wdata_d;
            o_dmem_mask  <= dmem_mask_d;
            o_valid      <= valid_d;
            o_wb_data    <= wb_data_d;
            o_rd         <= rd_out_d;
            o_reg_write  <= reg_write_out_d;
            o_excp       <= excp_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model predicts the write-back
// records, request windows and stall cycles, and one process compares every cycle.
module tb_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, i_mem_read, i_mem_write, i_reg_write;
    logic [2:0]  i_func3;
    logic [31:0] i_result, i_store_data, i_dmem_rdata;
    logic [4:0]  i_rd;
    logic        i_dmem_ready, i_dmem_rvalid;
    logic        o_stall, o_dmem_req, o_dmem_we, o_valid, o_reg_write, o_excp;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
    logic [3:0]  o_dmem_mask;
    logic [4:0]  o_rd;

    always #5 i_clk = ~i_clk;

    mem_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_func3(i_func3),
        .i_result(i_result), .i_store_data(i_store_data), .i_rd(i_rd),
        .i_reg_write(i_reg_write), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_mask(o_dmem_mask), .i_dmem_ready(i_dmem_ready),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd(o_rd),
        .o_reg_write(o_reg_write), .o_excp(o_excp)
    );

    typedef struct {
        int          cyc;
        logic [31:0] wb;
        logic [4:0]  rd;
        bit          rw;
        bit          excp;
        bit          chk_wb;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        cmp_rec;
    bit          stall_exp[0:1023];
    bit          req_exp[0:1023];
    bit          req_we[0:1023];
    logic [31:0] req_addr[0:1023];
    logic [31:0] req_wdata[0:1023];
    logic [3:0]  req_mask[0:1023];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Access size in bytes implied by the width code.
    function automatic int width_of(logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_excp(bit ld, logic [2:0] f3, logic [31:0] a);
        if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if (!ld && f3 > 3'd2) return 1'b1;
        return (int'(a[1:0]) % width_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_mask(bit ld, logic [2:0] f3, logic [31:0] a);
        int b = int'(a[1:0]);
        if (ld) return 4'hF;
        case (width_of(f3))
            1:       return 4'(1 << b);
            2:       return 4'(3 << b);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(bit ld, logic [2:0] f3, logic [31:0] d);
        if (ld) return 32'd0;
        case (width_of(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
        int          w = width_of(f3);
        logic [63:0] u;
        if (w == 4) return word;
        u = {32'd0, word} >> (8 * int'(a[1:0]));
        u = u % (64'd1 << (8 * w));
        if (f3 < 3'd4 && u >= (64'd1 << (8 * w - 1))) u = u - (64'd1 << (8 * w));
        return u[31:0];
    endfunction

    always @(negedge i_clk) begin
        if (chk_on) begin
            check_output("stall", 32'(o_stall), 32'(stall_exp[cyc]));
            check_output("dmem_req", 32'(o_dmem_req), 32'(req_exp[cyc]));
            if (req_exp[cyc]) begin
                check_output("dmem_we", 32'(o_dmem_we), 32'(req_we[cyc]));
                check_output("dmem_addr", o_dmem_addr, req_addr[cyc]);
                check_output("dmem_wdata", o_dmem_wdata, req_wdata[cyc]);
                check_output("dmem_mask", 32'(o_dmem_mask), 32'(req_mask[cyc]));
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                cmp_rec = exp_q.pop_front();
                check_output("valid", 32'(o_valid), 32'd1);
                check_output("reg_write", 32'(o_reg_write), 32'(cmp_rec.rw));
                check_output("excp", 32'(o_excp), 32'(cmp_rec.excp));
                if (cmp_rec.rw) check_output("rd", 32'(o_rd), 32'(cmp_rec.rd));
                if (cmp_rec.chk_wb) check_output("wb_data", o_wb_data, cmp_rec.wb);
            end else begin
                check_output("valid", 32'(o_valid), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_mem_bus();
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = $urandom;
    endtask

    task automatic drive_junk();
        i_valid      = 1'b1;
        i_mem_read   = 1'($urandom % 2);
        i_mem_write  = 1'b0;
        i_func3      = 3'($urandom);
        i_result     = $urandom;
        i_store_data = $urandom;
        i_rd         = 5'($urandom);
        i_reg_write  = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            step();
            clear_mem_bus();
            i_valid     = 1'b0;
            i_mem_read  = 1'b0;
            i_mem_write = 1'b0;
        end
    endtask

    task automatic apply_alu(logic [31:0] res, logic [4:0] rd, bit rw);
        rec_t r;
        step();
        clear_mem_bus();
        i_valid      = 1'b1;
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b0;
        i_func3      = 3'($urandom);
        i_result     = res;
        i_store_data = $urandom;
        i_rd         = rd;
        i_reg_write  = rw;
        r.cyc = cyc + 1; r.wb = res; r.rd = rd; r.rw = rw; r.excp = 1'b0; r.chk_wb = 1'b1;
        exp_q.push_back(r);
    endtask

    // Issues one load/store; ready comes rdy_dly cycles late, rvalid rv_dly cycles into RESP.
    task automatic apply_mem(bit ld, logic [2:0] f3, logic [31:0] addr, logic [31:0] sdata,
                             logic [4:0] rd, int rdy_dly, int rv_dly, logic [31:0] word);
        rec_t r;
        int   c, rq, done;
        step();
        clear_mem_bus();
        i_dmem_rvalid = 1'b1;
        i_valid       = 1'b1;
        i_mem_read    = ld;
        i_mem_write   = !ld;
        i_func3       = f3;
        i_result      = addr;
        i_store_data  = sdata;
        i_rd          = rd;
        i_reg_write   = 1'b1;
        c = cyc;
        r.rd = rd; r.excp = 1'b0;
        if (model_excp(ld, f3, addr)) begin
            r.cyc = c + 1; r.wb = addr; r.rw = 1'b0; r.excp = 1'b1; r.chk_wb = 1'b1;
            exp_q.push_back(r);
            return;
        end
        rq = c + 1 + rdy_dly;
        for (int k = c + 1; k <= rq; k++) begin
            req_exp[k]   = 1'b1;
            req_we[k]    = !ld;
            req_addr[k]  = addr & ~32'd3;
            req_wdata[k] = model_wdata(ld, f3, sdata);
            req_mask[k]  = model_mask(ld, f3, addr);
        end
        if (ld) begin
            done = rq + 1 + rv_dly;
            r.wb = model_load(f3, addr, word); r.rw = 1'b1; r.chk_wb = 1'b1;
        end else begin
            done = rq;
            r.wb = 32'd0; r.rw = 1'b0; r.chk_wb = 1'b0;
        end
        r.cyc = done + 1;
        for (int k = c + 1; k <= done; k++) stall_exp[k] = 1'b1;
        exp_q.push_back(r);
        while (cyc < done) begin
            step();
            clear_mem_bus();
            drive_junk();
            if (cyc == rq) begin
                i_dmem_ready  = 1'b1;
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = ~word;
            end else if (ld && cyc == done) begin
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = word;
            end else if (cyc < rq) begin
                i_dmem_rvalid = 1'($urandom % 2);
            end
        end
    endtask

    task automatic check_all_zero(string tag);
        check_output({tag, "_valid"}, 32'(o_valid), 32'd0);
        check_output({tag, "_wb_data"}, o_wb_data, 32'd0);
        check_output({tag, "_rd"}, 32'(o_rd), 32'd0);
        check_output({tag, "_reg_write"}, 32'(o_reg_write), 32'd0);
        check_output({tag, "_excp"}, 32'(o_excp), 32'd0);
        check_output({tag, "_req"}, 32'(o_dmem_req), 32'd0);
        check_output({tag, "_we"}, 32'(o_dmem_we), 32'd0);
        check_output({tag, "_addr"}, o_dmem_addr, 32'd0);
        check_output({tag, "_wdata"}, o_dmem_wdata, 32'd0);
        check_output({tag, "_mask"}, 32'(o_dmem_mask), 32'd0);
        check_output({tag, "_stall"}, 32'(o_stall), 32'd0);
    endtask

    // Load accepted, handshake done, reset dropped in while the block waits in RESP.
    task automatic apply_reset_in_resp();
        int c;
        step();
        clear_mem_bus();
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_func3 = 3'b010;
        i_result = 32'h0000_0300; i_store_data = 32'd0; i_rd = 5'd4; i_reg_write = 1'b1;
        c = cyc;
        req_exp[c + 1] = 1'b1; req_we[c + 1] = 1'b0; req_addr[c + 1] = 32'h300;
        req_wdata[c + 1] = 32'd0; req_mask[c + 1] = 4'hF;
        stall_exp[c + 1] = 1'b1;
        stall_exp[c + 2] = 1'b1;
        step();
        clear_mem_bus();
        drive_junk();
        i_dmem_ready = 1'b1;
        step();
        clear_mem_bus();
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        #2;
        check_all_zero("mid_reset");
    endtask

    initial begin
        check_output("pin_lb", model_load(3'b000, 32'h102, 32'h12F4_5678), 32'hFFFF_FFF4);
        check_output("pin_lbu", model_load(3'b100, 32'h102, 32'h12F4_5678), 32'h0000_00F4);
        check_output("pin_lh", model_load(3'b001, 32'h106, 32'h8001_7FFF), 32'hFFFF_8001);
        check_output("pin_sb_mask", 32'(model_mask(1'b0, 3'b000, 32'h103)), 32'h8);
        check_output("pin_sb_wdata", model_wdata(1'b0, 3'b000, 32'hAABB_CCDD), 32'hDDDD_DDDD);
        check_output("pin_lw_excp", 32'(model_excp(1'b1, 3'b010, 32'h202)), 32'd1);

        i_rst_n = 1'b0;
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_func3 = 3'd0;
        i_result = 32'd0; i_store_data = 32'd0; i_rd = 5'd0; i_reg_write = 1'b0;
        clear_mem_bus();
        repeat (3) step();
        check_all_zero("reset");
        i_rst_n = 1'b1;
        chk_on  = 1'b1;
        idle(1);

        apply_alu(32'h0000_1234, 5'd5, 1'b1);
        apply_mem(1'b0, 3'b000, 32'h103, 32'hAABB_CCDD, 5'd7, 0, 0, 32'd0);
        apply_mem(1'b1, 3'b000, 32'h102, 32'd0, 5'd9, 0, 1, 32'h12F4_5678);
        apply_mem(1'b1, 3'b100, 32'h102, 32'd0, 5'd10, 0, 1, 32'h12F4_5678);
        apply_mem(1'b1, 3'b010, 32'h202, 32'd0, 5'd11, 0, 0, 32'd0);
        apply_mem(1'b1, 3'b001, 32'h106, 32'd0, 5'd12, 3, 0, 32'h8001_7FFF);
        idle(1);
        apply_mem(1'b0, 3'b001, 32'h102, 32'h1234_BEEF, 5'd1, 1, 0, 32'd0);
        apply_mem(1'b0, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd2, 0, 0, 32'd0);
        apply_mem(1'b0, 3'b010, 32'h41, 32'h1111_1111, 5'd3, 0, 0, 32'd0);
        apply_mem(1'b0, 3'b011, 32'h48, 32'h2222_2222, 5'd3, 0, 0, 32'd0);
        apply_mem(1'b1, 3'b101, 32'h100, 32'd0, 5'd13, 0, 2, 32'h1234_ABCD);
        apply_mem(1'b1, 3'b010, 32'h80, 32'd0, 5'd14, 2, 1, 32'hCAFE_F00D);
        apply_mem(1'b1, 3'b000, 32'h101, 32'd0, 5'd15, 0, 0, 32'h1234_5678);
        apply_mem(1'b1, 3'b110, 32'h100, 32'd0, 5'd16, 0, 0, 32'd0);
        apply_alu(32'h0000_0001, 5'd20, 1'b1);
        apply_alu(32'hFFFF_0000, 5'd21, 1'b0);
        apply_alu(32'h8000_0000, 5'd22, 1'b1);
        idle(2);

        apply_reset_in_resp();
        apply_alu(32'h0000_5A5A, 5'd6, 1'b1);
        idle(3);
        check_output("pending_records", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined RV32I hart, directly downstream of the execute stage. Consumes the ALU result as an effective address plus the store operand. Runs a request/response handshake with data memory, formats store byte-lanes and load sign/zero-extension, and hands a registered write-back record to the write-back stage. Non-memory instructions pass through with one cycle of latency. The block stalls the upstream pipeline while a memory transaction is outstanding.

## Interface

Parameters: none (XLEN fixed at 32).

- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  upstream instruction present
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store
- i_func3  in  3  load/store width code
- i_result  in  32  ALU result; effective address for loads/stores, write-back value otherwise
- i_store_data  in  32  rs2 value for stores
- i_rd  in  5  destination register
- i_reg_write  in  1  instruction writes rd
- o_stall  out  1  combinational; upstream must hold its outputs while high
- o_dmem_req  out  1  memory request valid
- o_dmem_we  out  1  request is a write
- o_dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_mask  out  4  byte-enable, bit n = byte n
- i_dmem_ready  in  1  memory accepts request this cycle
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  32  load data word
- o_valid  out  1  write-back record valid (one-cycle pulse per instruction)
- o_wb_data  out  32  value for rd
- o_rd  out  5  destination register
- o_reg_write  out  1  rd write enable (forced 0 on exception)
- o_excp  out  1  misaligned access or undefined width

## Operation

- States: IDLE, REQ, RESP.
- Acceptance: in IDLE, i_valid=1 accepts the instruction; all inputs are captured into internal registers. Outside IDLE, inputs are ignored.
- Non-memory instruction (i_mem_read=i_mem_write=0): next cycle o_valid=1, o_wb_data=i_result, o_rd/o_reg_write copied, o_excp=0; state stays IDLE.
- Exception check at acceptance: word access with addr[1:0]≠0; half access with addr[0]≠0; load func3 ∈ {011,110,111}; store func3 ∉ {000,001,010}.
  - On exception: no memory request. Next cycle o_valid=1, o_excp=1, o_reg_write=0, o_wb_data=i_result. State stays IDLE.
- Valid memory op: next cycle state=REQ and o_dmem_req=1. o_dmem_we=i_mem_write; addr, wdata and mask are registered.
  - Request fields are held constant until the handshake completes.
- Store formatting:
  - sb: mask=4'b0001<<addr[1:0], wdata={4{data[7:0]}}
  - sh: mask=4'b0011<<addr[1:0], wdata={2{data[15:0]}}
  - sw: mask=4'b1111, wdata=data
  - For loads, mask=4'b1111 and wdata=0.
- REQ: on i_dmem_ready=1, o_dmem_req drops the next cycle.
  - Store: next cycle o_valid=1, o_reg_write=0, state→IDLE.
  - Load: state→RESP.
- RESP: i_dmem_rvalid is sampled only in this state; it is ignored in IDLE and REQ. On rvalid, the selected lane is extended:
  - lb/lbu: byte addr[1:0], sign- or zero-extended
  - lh/lhu: half addr[1], sign- or zero-extended
  - lw: whole word
  - Next cycle: o_valid=1, o_wb_data=formatted value, state→IDLE.
- o_stall = (state≠IDLE). It is never asserted in the cycle the memory op is accepted, so the following instruction is presented upstream and held.
- Reset mid-transaction: the outstanding request is abandoned and the state returns to IDLE. Memory must tolerate the dropped request.

## Timing

- Reset values: o_valid=0, o_wb_data=0, o_rd=0, o_reg_write=0, o_excp=0, o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_wdata=0, o_dmem_mask=0, state=IDLE, o_stall=0.
- All outputs are registered except o_stall.
- o_valid is high for exactly one cycle per accepted instruction and is 0 in every other cycle.
- Latency (accept at cycle 0, ready/rvalid at first opportunity):
  - non-memory or exception: o_valid at cycle 1
  - store: req at cycle 1, o_valid at cycle 2
  - load: req at cycle 1, RESP at cycle 2, o_valid at cycle 3
- Each cycle of ready/rvalid delay adds one cycle of latency and one cycle of o_stall.
- An rvalid that arrives in the same cycle as ready is ignored.
- Back-to-back non-memory instructions sustain one instruction per cycle.
- When o_valid is asserted in the cycle the block returns to IDLE, a new instruction is accepted in that same cycle.

## Test plan

- ADD result 0x0000_1234, rd=5, reg_write=1 → cycle 1: o_valid=1, o_wb_data=0x1234, o_rd=5, no dmem_req, o_stall=0 throughout.
- sb addr=0x103, data=0xAABBCCDD, ready at once → cycle 1: req=1, we=1, addr=0x100, mask=4'b1000, wdata=0xDDDDDDDD; cycle 2: o_valid=1, o_reg_write=0.
- lb addr=0x102, memory word 0x12F45678, ready at cycle 1, rvalid at cycle 3 → o_wb_data=0xFFFFFFF4 at cycle 4; o_stall high cycles 1–3. Repeat with lbu → 0x000000F4.
- lw addr=0x202 → no request; cycle 1: o_valid=1, o_excp=1, o_reg_write=0.
- lh in REQ with ready held low 3 cycles → addr, mask and req are stable across those cycles, and stall covers them.
- Reset asserted in RESP → next cycle every output is 0 and state is IDLE. A following ADD completes normally with o_valid one cycle after acceptance.
